myproject_sdiv_seq_22s_6s_16: RTL and testbench
===============================================

Name: myproject_sdiv_seq_22s_6s_16

Overview:
- Sequential signed divider; the inverse operation to the 16s x 6s -> 22 multiplier primitive.
- Divides a 22-bit signed dividend (a product or accumulator value) by a 6-bit signed weight.
- Returns a saturated 16-bit signed quotient and a 6-bit signed remainder.
- Uses one radix-2 restoring iteration per cycle, behind valid/ready handshakes, for the rescale/normalize layers.

Parameters:
- ID, 1, instance identifier; no functional effect.
- DIVIDEND_WIDTH, 22, dividend width; fixed at 22 for this block.
- DIVISOR_WIDTH, 6, divisor width; fixed at 6.
- QUOTIENT_WIDTH, 16, output quotient width; fixed at 16.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  dividend/divisor pair is valid.
- in_ready  out  1  block can accept a pair.
- din0  in  22  signed dividend.
- din1  in  6  signed divisor.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- quot  out  16  signed quotient, saturated.
- rem  out  6  signed remainder.
- ovf  out  1  quotient was saturated.
- dbz  out  1  divisor was zero.

Behaviour:
- Reset (ap_rst_n low, asynchronous): state=IDLE; in_ready=0 while in reset, then 1; out_valid=0; quot=0, rem=0, ovf=0, dbz=0.
  - Reset mid-CALC/FIX/DONE aborts the operation. No out_valid is produced for an aborted operation.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture operands and go to CALC.
  - CALC: runs 22 iterations, counter 21 down to 0, then goes to FIX.
  - FIX: applies signs and saturation, then goes to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready is 0 in CALC, FIX and DONE. There is no input pipelining; one operation is in flight at a time.
- Capture step:
  - Latch sign(din0), sign(din1) and sign(din0)^sign(din1).
  - Latch magnitudes as 22-bit |din0| and 6-bit |din1|.
  - |-2^21| = 2^21 must fit: use an unsigned 22-bit magnitude.
  - |-32| = 32 uses the 6-bit unsigned magnitude.
- CALC iteration:
  - Shift the partial remainder (7 bits) left, bringing in the next dividend MSB.
  - Subtract the divisor magnitude; if the result is non-negative, keep it and set the quotient bit to 1, otherwise restore.
  - This produces a 22-bit unsigned quotient magnitude Q and remainder magnitude R, with R < |din1|.
- Semantics: C truncation toward zero; rem has the sign of the dividend; din0 = q*din1 + rem exactly when not saturated.
- FIX step:
  - q = negate-if-sign(Q).
  - If q > 32767, set quot=32767 and ovf=1.
  - If q < -32768, set quot=-32768 and ovf=1.
  - Otherwise quot=q[15:0] and ovf=0.
  - rem = negate-if-dividend-negative(R); it always fits in 6 bits signed (|R| <= 31).
- Divide by zero (din1=0):
  - dbz=1, ovf=0, rem=0.
  - quot=32767 if din0 >= 0, else -32768.
  - Same latency as a normal divide.
- Latency: constant. out_valid rises 24 edges after the accepting edge (22 CALC + FIX + entry to DONE).
  - With out_ready held high, a new input is accepted 1 cycle after the output handshake. Throughput is 1 result per 26 cycles.
- Output stability: quot, rem, ovf and dbz are registered.
  - They hold stable while out_valid=1 and out_ready=0, for any number of cycles.
  - They retain their last values after the handshake, until the next FIX.
- in_valid is ignored outside IDLE; the operands are not re-sampled.

Test Plan:
- din0=1000, din1=7 -> after 24 cycles: quot=142, rem=6, ovf=0, dbz=0. Then din0=-1000, din1=7 -> quot=-142, rem=-6.
- din0=1000, din1=-32 -> quot=-31, rem=8. Then din0=-2097152, din1=-32 -> quot=32767, ovf=1, rem=0 (true quotient 65536).
- din0=-2097152, din1=1 -> quot=-32768, ovf=1, rem=0. Then din0=2097151, din1=31 -> true quotient 67650, so quot=32767, ovf=1, rem=1.
- Divide by zero: din0=5, din1=0 -> quot=32767, dbz=1, rem=0. Then din0=-5, din1=0 -> quot=-32768, dbz=1. Both take 24-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, and a new in_valid pulse is ignored. Release -> IDLE, in_ready=1 the next cycle.
- Reset mid-operation: assert ap_rst_n=0 at CALC iteration 10 -> out_valid=0 and in_ready=0 immediately (asynchronous). After release: in_ready=1, no stale result; a fresh 1000/7 still yields 142 r 6.
- Randomized: 10k random operand pairs checked against a reference model; also check din0 = quot*din1 + rem whenever ovf=0 and dbz=0.

Source files
------------

// File: rtl/myproject_sdiv_seq_22s_6s_16.sv
// Sequential signed divider: 22-bit signed dividend / 6-bit signed divisor, one restoring
// step per cycle, returning a saturated 16-bit quotient, the remainder, and overflow/zero flags.
module myproject_sdiv_seq_22s_6s_16 #(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = 22,
  parameter int DIVISOR_WIDTH  = 6,
  parameter int QUOTIENT_WIDTH = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      ovf,
  output logic                      dbz
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int SW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int CW = $clog2(DW);
  localparam int Q_MAX_INT = (1 << (QW - 1)) - 1;
  localparam int Q_MIN_INT = -(1 << (QW - 1));
  localparam logic signed [DW:0] Q_MAX = Q_MAX_INT[DW:0];
  localparam logic signed [DW:0] Q_MIN = Q_MIN_INT[DW:0];
  localparam logic [QW-1:0] Q_MAX_BITS = {1'b0, {(QW - 1){1'b1}}};
  localparam logic [QW-1:0] Q_MIN_BITS = {1'b1, {(QW - 1){1'b0}}};

  if (DW != 22 || SW != 6 || QW != 16 || ID < 0) begin : g_unsupported
    $error("myproject_sdiv_seq_22s_6s_16: only the 22s/6s/16 configuration is supported");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          count_reg;
  logic                   fix_phase_reg;
  logic [DW-1:0]          dvd_reg;
  logic [DW-1:0]          quo_reg;
  logic [SW-1:0]          dvs_reg;
  logic [SW:0]            prem_reg;
  logic                   sign_a_reg;
  logic                   sign_q_reg;
  logic                   zero_reg;
  logic signed [DW:0]     q_signed_reg;
  logic [SW-1:0]          r_signed_reg;
  logic [QW-1:0]          quot_reg;
  logic [SW-1:0]          rem_reg;
  logic                   ovf_reg;
  logic                   dbz_reg;

  logic                   accept;
  logic [SW:0]            shifted;
  logic [SW+1:0]          diff;
  logic                   qbit;
  logic [DW-1:0]          mag_a;
  logic [SW-1:0]          mag_b;

  // in_ready is forced low while reset is held, not just after the first edge.
  assign in_ready  = (state_reg == IDLE) & ap_rst_n;
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid & in_ready;
  assign quot      = quot_reg;
  assign rem       = rem_reg;
  assign ovf       = ovf_reg;
  assign dbz       = dbz_reg;

  always_comb begin
    shifted = {prem_reg[SW-1:0], dvd_reg[DW-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_reg};
    qbit    = ~diff[SW+1];
    mag_a   = din0[DW-1] ? (~din0 + 1'b1) : din0;
    mag_b   = din1[SW-1] ? (~din1 + 1'b1) : din1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (count_reg == '0) state_next = FIX;
      FIX:     if (fix_phase_reg) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count_reg     <= '0;
      fix_phase_reg <= 1'b0;
      dvd_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      prem_reg      <= '0;
      sign_a_reg    <= 1'b0;
      sign_q_reg    <= 1'b0;
      zero_reg      <= 1'b0;
      q_signed_reg  <= '0;
      r_signed_reg  <= '0;
      quot_reg      <= '0;
      rem_reg       <= '0;
      ovf_reg       <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          // Magnitudes are unsigned so |-2^21| and |-32| are representable.
          dvd_reg    <= mag_a;
          dvs_reg    <= mag_b;
          quo_reg    <= '0;
          prem_reg   <= '0;
          sign_a_reg <= din0[DW-1];
          sign_q_reg <= din0[DW-1] ^ din1[SW-1];
          zero_reg   <= (din1 == '0);
          count_reg  <= CW'(DW - 1);
        end
        CALC: begin
          dvd_reg  <= {dvd_reg[DW-2:0], 1'b0};
          quo_reg  <= {quo_reg[DW-2:0], qbit};
          prem_reg <= qbit ? diff[SW:0] : shifted;
          if (count_reg == '0) fix_phase_reg <= 1'b0;
          else                 count_reg     <= count_reg - 1'b1;
        end
        FIX: begin
          if (!fix_phase_reg) begin
            // First half applies signs; second half saturates into the output registers.
            q_signed_reg  <= sign_q_reg ? -$signed({1'b0, quo_reg}) : $signed({1'b0, quo_reg});
            r_signed_reg  <= sign_a_reg ? -prem_reg[SW-1:0] : prem_reg[SW-1:0];
            fix_phase_reg <= 1'b1;
          end else if (zero_reg) begin
            quot_reg <= sign_a_reg ? Q_MIN_BITS : Q_MAX_BITS;
            rem_reg  <= '0;
            ovf_reg  <= 1'b0;
            dbz_reg  <= 1'b1;
          end else begin
            dbz_reg <= 1'b0;
            rem_reg <= r_signed_reg;
            if (q_signed_reg > Q_MAX) begin
              quot_reg <= Q_MAX_BITS;
              ovf_reg  <= 1'b1;
            end else if (q_signed_reg < Q_MIN) begin
              quot_reg <= Q_MIN_BITS;
              ovf_reg  <= 1'b1;
            end else begin
              quot_reg <= q_signed_reg[QW-1:0];
              ovf_reg  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_sdiv_seq_22s_6s_16.sv
// Directed and model-checked stimulus for the sequential signed divider.
module tb_myproject_sdiv_seq_22s_6s_16;

  logic        ap_clk    = 1'b0;
  logic        ap_rst_n  = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [21:0] din0      = '0;
  logic [5:0]  din1      = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] quot;
  logic [5:0]  rem;
  logic        ovf;
  logic        dbz;

  int check_count = 0;
  int pass_count  = 0;

  always #5 ap_clk = ~ap_clk;

  myproject_sdiv_seq_22s_6s_16 dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  task automatic check(input string tag, input int observed, input int expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic start_op(input int a, input int b);
    @(negedge ap_clk);
    din0     = 22'(a);
    din1     = 6'(b);
    in_valid = 1'b1;
    check("in_ready_idle", int'(in_ready), 1);
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge ap_clk);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", int'(out_valid), 0);
    check("post_hs_in_ready", int'(in_ready), 1);
  endtask

  task automatic do_op(input int a, input int b, input int eq, input int er,
                       input int eovf, input int edbz, input string tag);
    int lat;
    start_op(a, b);
    wait_result(lat);
    check({tag, "_latency"}, lat, 24);
    check({tag, "_quot"}, int'($signed(quot)), eq);
    check({tag, "_rem"}, int'($signed(rem)), er);
    check({tag, "_ovf"}, int'(ovf), eovf);
    check({tag, "_dbz"}, int'(dbz), edbz);
    $display("op %s: din0=%0d din1=%0d -> quot=%0d rem=%0d ovf=%0d dbz=%0d lat=%0d",
             tag, a, b, $signed(quot), $signed(rem), ovf, dbz, lat);
    handshake();
  endtask

  // Reference: C truncating division, saturated to 16 bits; zero divisor handled separately.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int o, output int z);
    int tq;
    if (b == 0) begin
      q = (a >= 0) ? 32767 : -32768;
      r = 0; o = 0; z = 1;
    end else begin
      tq = a / b;
      r  = a % b;
      z  = 0;
      o  = 0;
      q  = tq;
      if (tq > 32767)  begin q = 32767;  o = 1; end
      if (tq < -32768) begin q = -32768; o = 1; end
    end
  endfunction

  initial begin
    int lat;
    bit seen;

    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quot", int'(quot), 0);
    check("rst_rem", int'(rem), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_dbz", int'(dbz), 0);
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    do_op(1000, 7, 142, 6, 0, 0, "pos_div");
    do_op(-1000, 7, -142, -6, 0, 0, "neg_dividend");
    do_op(1000, -32, -31, 8, 0, 0, "neg32_divisor");
    do_op(-2097152, -32, 32767, 0, 1, 0, "min_by_neg32");
    do_op(-2097152, 1, -32768, 0, 1, 0, "min_by_one");
    do_op(2097151, 31, 32767, 1, 1, 0, "max_by_31");
    do_op(5, 0, 32767, 0, 0, 1, "dbz_pos");
    do_op(-5, 0, -32768, 0, 0, 1, "dbz_neg");
    do_op(-32768, 1, -32768, 0, 0, 0, "exact_min");
    do_op(32768, 1, 32767, 0, 1, 0, "just_over_max");
    do_op(-7, 2, -3, -1, 0, 0, "small_neg");
    do_op(0, -5, 0, 0, 0, 0, "zero_dividend");

    // Backpressure: outputs hold, in_ready stays low and a stray in_valid is ignored.
    start_op(100, 3);
    wait_result(lat);
    check("bp_latency", lat, 24);
    for (int k = 0; k < 10; k++) begin
      @(negedge ap_clk);
      if (k == 3) begin
        din0 = 22'(7); din1 = 6'(1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge ap_clk);
      #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_quot", int'($signed(quot)), 33);
      check("bp_rem", int'($signed(rem)), 1);
    end
    $display("op backpressure: quot=%0d rem=%0d held 10 cycles", $signed(quot), $signed(rem));
    handshake();
    check("bp_retained_quot", int'($signed(quot)), 33);
    seen = 1'b0;
    repeat (30) begin
      @(posedge ap_clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("bp_no_stray_op", int'(seen), 0);

    // Asynchronous reset in the middle of CALC.
    start_op(1000, 7);
    repeat (10) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    check("mid_rst_quot", int'(quot), 0);
    check("mid_rst_rem", int'(rem), 0);
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("after_rst_in_ready", int'(in_ready), 1);
    seen = 1'b0;
    repeat (30) begin
      @(posedge ap_clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("after_rst_no_stale", int'(seen), 0);
    $display("op mid_reset: aborted, no stale result");
    do_op(1000, 7, 142, 6, 0, 0, "post_reset");

    // Random operands against the reference model plus the division identity.
    for (int i = 0; i < 150; i++) begin
      logic [21:0] ra;
      logic [5:0]  rb;
      int a, b, eq, er, eo, ez;
      ra = 22'($urandom);
      rb = 6'($urandom);
      if (i % 2 == 0) ra = {{8{ra[21]}}, ra[13:0]};
      if (i % 25 == 0) rb = '0;
      a = int'($signed(ra));
      b = int'($signed(rb));
      model(a, b, eq, er, eo, ez);
      do_op(a, b, eq, er, eo, ez, "rand");
      if (eo == 0 && ez == 0)
        check("rand_identity", int'($signed(quot)) * b + int'($signed(rem)), a);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
